xstep_sequencer: RTL and testbench

Memory-mapped, parametrised step sequencer peripheral for the picoVersat data bus, replacing the fixed loop controller / switch / LED driver cluster with one block. It holds a `STEPS`-entry table of tone periods, steps through the table at a programmable tempo, and outputs a square-wave tone. Keyboard switches toggle per-step enables, and LEDs show either the playhead or the enable mask. It sits behind the address decoder like any other slave, with its own select line.

---
 rtl/xstep_sequencer.sv | 164 ++++++++++++++++
 tb/tb_xstep_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/xstep_sequencer.sv
// xstep_sequencer: bus-mapped step sequencer holding a tone-period table, a
// programmable tempo, keyboard-toggled step enables and an LED playhead.
// state | meaning
// IDLE  | stopped, step index held, LEDs show ENABLE
// PLAY  | stepping through the table, LEDs show the playhead
// DONE  | non-looping sequence finished, done flag set
module xstep_sequencer #(
    parameter int DATA_W  = 32,
    parameter int STEPS   = 8,
    parameter int TONE_W  = 16,
    parameter int TEMPO_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [STEPS-1:0]  kbd_in,
    output logic              snd_out,
    output logic [STEPS-1:0]  led_out,
    output logic              done
);
    localparam int PTR_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DONE = 2'd2} state_t;
    state_t state_q, state_d;

    logic               run_q, loop_q, done_q, snd_q;
    logic [TEMPO_W-1:0] tempo_q, tempo_cnt_q;
    logic [PTR_W-1:0]   step_q, ptr_q;
    logic [STEPS-1:0]   enable_q, sync1_q, sync2_q, sync3_q;
    logic [TONE_W-1:0]  tbl_q [STEPS];
    logic [TONE_W-1:0]  tone_cnt_q, cur_period;

    logic wr, wr_ctrl, wr_tempo, wr_enable, wr_ptr, wr_period;
    logic ctrl_run, ctrl_loop, ctrl_clr;
    logic playing, tempo_hit, last_step, step_adv, seq_end, step_restart, tone_active;
    logic [STEPS-1:0] kbd_rise;
    logic [3:0] step_ext;
    logic unused_data;

    assign wr        = sel & we;
    assign wr_ctrl   = wr && (addr == 3'd0);
    assign wr_tempo  = wr && (addr == 3'd1);
    assign wr_enable = wr && (addr == 3'd3);
    assign wr_ptr    = wr && (addr == 3'd4);
    assign wr_period = wr && (addr == 3'd5);
    assign ctrl_run  = data_in[0];
    assign ctrl_loop = data_in[1];
    assign ctrl_clr  = data_in[2];
    assign unused_data = ^data_in;

    assign playing      = (state_q == S_PLAY);
    assign cur_period   = tbl_q[step_q];
    assign tempo_hit    = (tempo_cnt_q >= tempo_q);
    assign last_step    = (step_q == LAST);
    // A CTRL write owns the cycle; the sequence does not advance underneath it.
    assign step_adv     = playing && !wr_ctrl && tempo_hit;
    assign seq_end      = step_adv && last_step && !loop_q;
    assign step_restart = step_adv || (wr_ctrl && ctrl_clr);
    assign kbd_rise     = sync2_q & ~sync3_q;
    assign step_ext     = 4'(step_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wr_ctrl)      state_d = ctrl_run ? S_PLAY : S_IDLE;
        else if (seq_end) state_d = S_DONE;
    end

    always_comb begin
        tone_active = playing && enable_q[step_q] && (cur_period != '0);
        snd_out     = snd_q & tone_active;
        led_out     = playing ? (STEPS'(1) << step_q) : enable_q;
        done        = done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            loop_q      <= 1'b0;
            done_q      <= 1'b0;
            snd_q       <= 1'b0;
            tempo_q     <= '0;
            tempo_cnt_q <= '0;
            step_q      <= '0;
            ptr_q       <= '0;
            enable_q    <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            tone_cnt_q  <= '0;
            for (int i = 0; i < STEPS; i++) tbl_q[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                run_q  <= ctrl_run;
                loop_q <= ctrl_loop;
                done_q <= 1'b0;
            end else if (seq_end) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end

            if (wr_ctrl && ctrl_clr) begin
                step_q      <= '0;
                tempo_cnt_q <= '0;
            end else if (step_adv) begin
                tempo_cnt_q <= '0;
                if (!last_step)  step_q <= step_q + 1'b1;
                else if (loop_q) step_q <= '0;
            end else if (playing && !wr_ctrl) begin
                tempo_cnt_q <= tempo_cnt_q + 1'b1;
            end

            if (wr_tempo) tempo_q <= data_in[TEMPO_W-1:0];

            if (wr_ptr) begin
                ptr_q <= (data_in < DATA_W'(STEPS)) ? data_in[PTR_W-1:0] : '0;
            end else if (wr_period) begin
                tbl_q[ptr_q] <= data_in[TONE_W-1:0];
                ptr_q        <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
            end

            // Bus write beats keyboard toggles landing in the same cycle.
            sync1_q <= kbd_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (wr_enable) enable_q <= data_in[STEPS-1:0];
            else           enable_q <= enable_q ^ kbd_rise;

            if (!tone_active || step_restart) begin
                tone_cnt_q <= '0;
                snd_q      <= 1'b0;
            end else if (tone_cnt_q >= cur_period) begin
                tone_cnt_q <= '0;
                snd_q      <= ~snd_q;
            end else begin
                tone_cnt_q <= tone_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                3'd0:    data_out = DATA_W'({loop_q, run_q});
                3'd1:    data_out = DATA_W'(tempo_q);
                3'd2:    data_out = DATA_W'({step_ext, 2'b00, done_q, playing});
                3'd3:    data_out = DATA_W'(enable_q);
                3'd4:    data_out = DATA_W'(ptr_q);
                3'd5:    data_out = DATA_W'(tbl_q[ptr_q]);
                default: data_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_xstep_sequencer.sv
// Self-checking bench for xstep_sequencer (STEPS=4): register vector table,
// hand sequences for keyboard/done/reset, and randomized playback vs a model.
module tb_xstep_sequencer;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic [3:0]  kbd_in = 4'd0;
    logic        snd_out;
    logic [3:0]  led_out;
    logic        done;

    int tests = 0;
    int fails = 0;
    int per[ST];
    int en_m;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    xstep_sequencer #(.DATA_W(32), .STEPS(ST), .TONE_W(16), .TEMPO_W(24)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .kbd_in(kbd_in),
        .snd_out(snd_out), .led_out(led_out), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_out;
        sel = 1'b0;
    endtask

    // Expected {done, snd, led} n cycles after the starting CTRL write.
    function automatic logic [5:0] model(input int n, input int t, input int lp);
        int total, k, s, o, p;
        logic snd;
        logic [3:0] led;
        logic [3:0] en;
        en = en_m[3:0];
        total = ST * (t + 1);
        if (lp == 0 && n >= total) return {1'b1, 1'b0, en};
        k = n % total;
        s = k / (t + 1);
        o = k % (t + 1);
        p = per[s];
        snd = (en[s] && p != 0) ? (((o / (p + 1)) % 2) == 1) : 1'b0;
        led = 4'b0001 << s;
        return {1'b0, snd, led};
    endfunction

    task automatic run_play(input int t, input int lp, input int ncyc, input string tag);
        wr(3'd0, 32'h4);
        wr(3'd1, t);
        wr(3'd4, 0);
        for (int i = 0; i < ST; i++) wr(3'd5, per[i]);
        wr(3'd3, en_m);
        wr(3'd0, (lp != 0) ? 32'h3 : 32'h1);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            chk($sformatf("%s n=%0d", tag, n), {26'd0, done, snd_out, led_out},
                {26'd0, model(n, t, lp)});
        end
    endtask

    initial begin
        logic [31:0] r;
        vec_t vt[$];
        int t, lp;

        for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 3'd0, 32'h0, 3'(i), 32'h0});
        vt.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 3'd1, 32'h00FF_FFFF});
        vt.push_back('{1'b1, 3'd3, 32'h0000_00FF, 3'd3, 32'h0000_000F});
        vt.push_back('{1'b1, 3'd4, 32'h0,         3'd4, 32'h0});
        vt.push_back('{1'b1, 3'd5, 32'd3,         3'd4, 32'd1});
        vt.push_back('{1'b1, 3'd5, 32'd5,         3'd4, 32'd2});
        vt.push_back('{1'b1, 3'd5, 32'd0,         3'd4, 32'd3});
        vt.push_back('{1'b1, 3'd5, 32'd7,         3'd4, 32'd0});
        vt.push_back('{1'b1, 3'd4, 32'd1,         3'd5, 32'd5});
        vt.push_back('{1'b0, 3'd0, 32'h0,         3'd4, 32'd1});
        vt.push_back('{1'b1, 3'd4, 32'd3,         3'd5, 32'd7});
        vt.push_back('{1'b1, 3'd6, 32'h55,        3'd6, 32'h0});
        vt.push_back('{1'b1, 3'd7, 32'hAA,        3'd7, 32'h0});
        vt.push_back('{1'b1, 3'd0, 32'h2,         3'd0, 32'h2});
        vt.push_back('{1'b1, 3'd0, 32'h4,         3'd0, 32'h0});
        vt.push_back('{1'b1, 3'd5, 32'h0001_2345, 3'd4, 32'h0});
        vt.push_back('{1'b1, 3'd4, 32'd3,         3'd5, 32'h2345});
        vt.push_back('{1'b0, 3'd0, 32'h0,         3'd2, 32'h0});
        vt.push_back('{1'b1, 3'd1, 32'd5,         3'd1, 32'd5});

        repeat (3) @(negedge clk);
        chk("reset outputs", {29'd0, done, snd_out, led_out == 4'd0}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset outputs", {26'd0, done, snd_out, led_out}, 32'h0);

        foreach (vt[i]) begin
            if (vt[i].we) wr(vt[i].waddr, vt[i].wdata);
            rd(vt[i].raddr, r);
            chk($sformatf("vec%0d", i), r, vt[i].exp);
        end

        sel = 1'b0; addr = 3'd1;
        #1;
        chk("sel0 read", data_out, 32'h0);

        // keyboard toggle lands 3 edges after the input change
        @(negedge clk);
        kbd_in[1] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rd(3'd3, r); chk("kbd before", r, 32'hF);
        @(posedge clk); #1;
        rd(3'd3, r); chk("kbd toggle", r, 32'hD);
        @(negedge clk);
        kbd_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        rd(3'd3, r); chk("kbd fall", r, 32'hD);
        kbd_in[1] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        wr(3'd3, 32'h3);
        rd(3'd3, r); chk("kbd vs write", r, 32'h3);
        repeat (3) @(negedge clk);
        rd(3'd3, r); chk("kbd vs write later", r, 32'h3);
        kbd_in[1] = 1'b0;
        repeat (4) @(negedge clk);

        per[0] = 3; per[1] = 5; per[2] = 0; per[3] = 7; en_m = 15;
        run_play(19, 1, 100, "loop");
        run_play(19, 0, 86, "noloop");
        rd(3'd2, r); chk("done status", r, 32'h32);
        chk("done led", {28'd0, led_out}, 32'hF);
        wr(3'd0, 32'h4);
        rd(3'd2, r); chk("clr status", r, 32'h0);
        chk("clr done", {31'd0, done}, 32'h0);

        wr(3'd1, 0);
        wr(3'd0, 32'h3);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            rd(3'd2, r);
            chk($sformatf("tempo0 n=%0d", n), r, 32'(((n % ST) << 4) | 1));
        end

        for (int it = 0; it < 8; it++) begin
            t = int'($urandom_range(0, 6));
            lp = int'($urandom_range(0, 1));
            for (int i = 0; i < ST; i++) per[i] = int'($urandom_range(0, 3));
            en_m = int'($urandom_range(0, 15));
            run_play(t, lp, ST * (t + 1) + 6, $sformatf("rand%0d", it));
        end

        per[0] = 3; per[1] = 5; per[2] = 0; per[3] = 7; en_m = 15;
        run_play(19, 1, 46, "pre-rst");
        rd(3'd2, r); chk("pre-rst status", r, 32'h21);
        rst = 1'b1;
        #1;
        chk("rst outputs", {26'd0, done, snd_out, led_out}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), r);
            chk($sformatf("rst read%0d", a), r, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post-rst outputs", {26'd0, done, snd_out, led_out}, 32'h0);
        rd(3'd2, r); chk("post-rst status", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
